// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a valid/ready byte stream into BYTES-wide words
// carrying a per-lane keep mask and a packet-last flag; lane order set by SWAP.
`default_nettype none

module byte_word_packer #(
   parameter int BYTES = 4,
   parameter bit SWAP  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*BYTES-1:0]   out_data,
   output logic [BYTES-1:0]     out_keep,
   output logic                 out_last
);

   localparam int              CW       = $clog2(BYTES);
   localparam logic [CW-1:0]   LAST_CNT = CW'(BYTES - 1);

   logic [8*BYTES-1:0] acc;
   logic [8*BYTES-1:0] merged_data;
   logic [BYTES-1:0]   keep;
   logic [BYTES-1:0]   merged_keep;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      lane;
   logic               accept;
   logic               complete;

   // The output register is the only stall source: a byte may enter whenever
   // the register is empty or being drained on this edge.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign complete = accept && ((cnt == LAST_CNT) || in_last);

   always_comb begin
      lane        = SWAP ? (LAST_CNT - cnt) : cnt;
      merged_data = acc;
      merged_keep = keep;
      merged_data[lane*8 +: 8] = in_data;
      merged_keep[lane]        = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         keep <= '0;
         cnt  <= '0;
      end else if (accept) begin
         if (complete) begin
            acc  <= '0;
            keep <= '0;
            cnt  <= '0;
         end else begin
            acc  <= merged_data;
            keep <= merged_keep;
            cnt  <= cnt + 1'b1;
         end
      end
   end

   // A completing byte reloads the register even while it is being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else if (complete) begin
         out_valid <= 1'b1;
         out_data  <= merged_data;
         out_keep  <= merged_keep;
         out_last  <= in_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire
